// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types, default code and width helpers for the keypad code lock.
package code_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_OPEN,
      ST_LOCKOUT,
      ST_PROG
   } state_e;

   localparam logic [15:0] DEFAULT_CODE = 16'h2327;

   function automatic int fail_w(input int max_fail);
      return $clog2(max_fail + 1);
   endfunction

   function automatic int tmr_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/code_lock_timer.sv
// code_lock_timer: shared down-counter; expired_o flags the cycle in which the count runs out.
module code_lock_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] load_val_i,
   input  logic         load_i,
   input  logic         run_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // Flagged while the last count is pending, so a load of N expires exactly N edges later.
   assign expired_o = run_i && (cnt_q == W'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code lock supervisor (digit entry, compare, fail/lockout, auto-close).
// Build option CODE_PROG_EN adds the PROG state for storing a new code while open.
//   state      | meaning
//   ST_IDLE    | waiting for the first digit
//   ST_ENTRY   | collecting digits, inter-digit timeout running
//   ST_CHECK   | one cycle: compare full entry against stored code
//   ST_OPEN    | lock open, auto-close timer running
//   ST_LOCKOUT | too many failures, digits ignored until timer expires
//   ST_PROG    | collecting a new code while staying open
module code_lock_ctrl #(
   parameter int DIGITS        = 4,
   parameter int DIGIT_W       = 4,
   parameter int MAX_FAIL      = 3,
   parameter int DIGIT_TMO_CYC = 500,
   parameter int OPEN_CYC      = 2000,
   parameter int LOCKOUT_CYC   = 1000,
   parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = code_lock_pkg::DEFAULT_CODE
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic [DIGIT_W-1:0]                            i_code,
   input  logic                                          i_code_vld,
   input  logic                                          i_close,
   input  logic                                          i_prog,
   output logic                                          o_open,
   output logic                                          o_locked,
   output logic                                          o_err,
   output logic [code_lock_pkg::fail_w(MAX_FAIL)-1:0]    o_fail_cnt,
   output logic                                          o_prog_done
);
   import code_lock_pkg::*;

   localparam int CW  = DIGITS * DIGIT_W;
   localparam int FW  = fail_w(MAX_FAIL);
   localparam int TW  = tmr_w(DIGIT_TMO_CYC, OPEN_CYC, LOCKOUT_CYC);
   localparam int DCW = $clog2(DIGITS + 1);

   state_e          state_q;
   logic [CW-1:0]   entry_q;
   logic [DCW-1:0]  dcnt_q;
   logic [FW-1:0]   fail_q;
   logic            open_q, locked_q, err_q;
   logic [CW-1:0]   code_w;
   logic [CW-1:0]   shifted;
   logic [FW-1:0]   fail_inc;
   logic            match, lock_hit, last_digit;
   logic            tmr_load, tmr_run, tmr_exp;
   logic [TW-1:0]   tmr_val;

`ifdef CODE_PROG_EN
   logic [CW-1:0]   code_q;
   logic            prog_done_q;
   assign code_w      = code_q;
   assign o_prog_done = prog_done_q;
`else
   logic            prog_unused;
   assign prog_unused = i_prog;
   assign code_w      = DEFAULT_CODE;
   assign o_prog_done = 1'b0;
`endif

   assign shifted    = (entry_q << DIGIT_W) | CW'(i_code);
   assign match      = (entry_q == code_w);
   assign fail_inc   = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
   assign lock_hit   = (fail_inc == FW'(MAX_FAIL));
   assign last_digit = (dcnt_q == DCW'(DIGITS - 1));
   assign tmr_run    = state_q inside {ST_ENTRY, ST_OPEN, ST_LOCKOUT, ST_PROG};

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE, ST_ENTRY: begin
            if (i_code_vld) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(DIGIT_TMO_CYC);
            end
         end
         ST_CHECK: begin
            if (match) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(OPEN_CYC);
            end else if (lock_hit) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(LOCKOUT_CYC);
            end
         end
`ifdef CODE_PROG_EN
         ST_OPEN: begin
            if (!(i_close || tmr_exp) && i_prog) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(DIGIT_TMO_CYC);
            end
         end
         ST_PROG: begin
            if (i_code_vld) begin
               tmr_load = 1'b1;
               tmr_val  = last_digit ? TW'(OPEN_CYC) : TW'(DIGIT_TMO_CYC);
            end else if (tmr_exp) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(OPEN_CYC);
            end
         end
`endif
         default: ;
      endcase
   end

   code_lock_timer #(.W(TW)) u_timer (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .load_val_i (tmr_val),
      .load_i     (tmr_load),
      .run_i      (tmr_run),
      .expired_o  (tmr_exp)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         entry_q  <= '0;
         dcnt_q   <= '0;
         fail_q   <= '0;
         open_q   <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef CODE_PROG_EN
         code_q      <= DEFAULT_CODE;
         prog_done_q <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
`ifdef CODE_PROG_EN
         prog_done_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (i_code_vld) begin
                  entry_q <= shifted;
                  dcnt_q  <= DCW'(1);
                  state_q <= (DIGITS == 1) ? ST_CHECK : ST_ENTRY;
               end
            end
            ST_ENTRY: begin
               if (i_code_vld) begin
                  entry_q <= shifted;
                  if (last_digit) begin
                     dcnt_q  <= '0;
                     state_q <= ST_CHECK;
                  end else begin
                     dcnt_q <= dcnt_q + DCW'(1);
                  end
               end else if (tmr_exp) begin
                  dcnt_q  <= '0;
                  state_q <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               if (match) begin
                  fail_q  <= '0;
                  open_q  <= 1'b1;
                  state_q <= ST_OPEN;
               end else begin
                  err_q  <= 1'b1;
                  fail_q <= fail_inc;
                  if (lock_hit) begin
                     locked_q <= 1'b1;
                     state_q  <= ST_LOCKOUT;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_OPEN: begin
               if (i_close || tmr_exp) begin
                  open_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
`ifdef CODE_PROG_EN
               else if (i_prog) begin
                  dcnt_q  <= '0;
                  state_q <= ST_PROG;
               end
`endif
            end
            ST_LOCKOUT: begin
               if (tmr_exp) begin
                  fail_q   <= '0;
                  locked_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
`ifdef CODE_PROG_EN
            ST_PROG: begin
               if (i_code_vld) begin
                  entry_q <= shifted;
                  if (last_digit) begin
                     code_q      <= shifted;
                     prog_done_q <= 1'b1;
                     dcnt_q      <= '0;
                     state_q     <= ST_OPEN;
                  end else begin
                     dcnt_q <= dcnt_q + DCW'(1);
                  end
               end else if (tmr_exp) begin
                  dcnt_q  <= '0;
                  state_q <= ST_OPEN;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_open     = open_q;
   assign o_locked   = locked_q;
   assign o_err      = err_q;
   assign o_fail_cnt = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: vector table, directed corner sequences and a randomized run against a reference model.
module tb_code_lock_ctrl;

   localparam int TMO = 8;
   localparam int OPN = 16;
   localparam int LCK = 12;
   localparam int MF  = 3;

   logic       clk = 1'b0;
   logic       i_rst, i_code_vld, i_close, i_prog;
   logic [3:0] i_code;
   logic       o_open, o_locked, o_err, o_prog_done;
   logic [1:0] o_fail_cnt;

   always #5 clk = ~clk;

   code_lock_ctrl #(
      .DIGITS(4), .DIGIT_W(4), .MAX_FAIL(MF),
      .DIGIT_TMO_CYC(TMO), .OPEN_CYC(OPN), .LOCKOUT_CYC(LCK),
      .DEFAULT_CODE(16'h2327)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_code(i_code), .i_code_vld(i_code_vld),
      .i_close(i_close), .i_prog(i_prog), .o_open(o_open), .o_locked(o_locked),
      .o_err(o_err), .o_fail_cnt(o_fail_cnt), .o_prog_done(o_prog_done)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: digit queue plus absolute-cycle deadlines.
   int          mq[$];
   logic [15:0] m_code;
   bit          m_check, m_open, m_locked, m_prog, m_err, m_pdone;
   int          m_fail, m_dl;

   function automatic logic [15:0] q2code();
      logic [15:0] v = '0;
      foreach (mq[i]) v = {v[11:0], 4'(mq[i])};
      return v;
   endfunction

   task automatic model_edge();
      cyc++;
      m_err   = 0;
      m_pdone = 0;
      if (i_rst) begin
         mq.delete();
         m_code = 16'h2327;
         m_check = 0; m_open = 0; m_locked = 0; m_prog = 0;
         m_fail = 0; m_dl = 0;
      end else if (m_check) begin
         m_check = 0;
         if (q2code() == m_code) begin
            m_open = 1; m_fail = 0; m_dl = cyc + OPN;
         end else begin
            m_err  = 1;
            m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
            if (m_fail == MF) begin
               m_locked = 1; m_dl = cyc + LCK;
            end
         end
         mq.delete();
      end else if (m_locked) begin
         if (cyc == m_dl) begin
            m_locked = 0; m_fail = 0;
         end
      end else if (m_prog) begin
         if (i_code_vld) begin
            mq.push_back(int'(i_code));
            m_dl = cyc + TMO;
            if (mq.size() == 4) begin
               m_code = q2code(); m_pdone = 1; m_prog = 0; m_dl = cyc + OPN;
               mq.delete();
            end
         end else if (cyc == m_dl) begin
            m_prog = 0; m_dl = cyc + OPN; mq.delete();
         end
      end else if (m_open) begin
         if (i_close || cyc == m_dl) m_open = 0;
`ifdef CODE_PROG_EN
         else if (i_prog) begin
            m_open = 0; m_prog = 1; m_dl = cyc + TMO; mq.delete();
         end
`endif
      end else begin
         if (i_code_vld) begin
            mq.push_back(int'(i_code));
            m_dl = cyc + TMO;
            if (mq.size() == 4) m_check = 1;
         end else if (mq.size() > 0 && cyc == m_dl) begin
            mq.delete();
         end
      end
   endtask

   function automatic logic [5:0] pk(input logic op, input logic lk, input logic er,
                                     input logic [1:0] fc, input logic pd);
      return {op, lk, er, fc, pd};
   endfunction

   function automatic logic [5:0] outs();
      return {o_open, o_locked, o_err, o_fail_cnt, o_prog_done};
   endfunction

   task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s at cycle %0d: {open,locked,err,fail,pdone} got %b expected %b",
                     nm, cyc, act, exp);
      end
   endtask

   task automatic step(input logic vld, input logic [3:0] code, input logic cls, input logic prg);
      i_code_vld = vld; i_code = code; i_close = cls; i_prog = prg;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0);
   endtask

   task automatic enter(input logic [15:0] c);
      for (int i = 0; i < 4; i++) step(1, 4'(c >> (4 * (3 - i))), 0, 0);
   endtask

   task automatic reset_dut();
      i_rst = 1'b1;
      idle(1);
      i_rst = 1'b0;
   endtask

   typedef struct {
      logic       vld;
      logic [3:0] code;
      logic       cls;
      logic       prg;
      logic       e_open;
      logic       e_locked;
      logic       e_err;
      logic [1:0] e_fail;
   } vec_t;

   vec_t        tbl[14];
   logic [15:0] pat;
   int          pos;

   initial begin
      tbl[0]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3]  = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[6]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[7]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[9]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[11] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

      i_rst = 1'b1; i_code_vld = 1'b0; i_code = 4'h0; i_close = 1'b0; i_prog = 1'b0;
      idle(2);
      chk("reset", outs(), pk(0, 0, 0, 2'd0, 0));
      i_rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].vld, tbl[i].code, tbl[i].cls, tbl[i].prg);
         chk($sformatf("vec%0d", i), outs(),
             pk(tbl[i].e_open, tbl[i].e_locked, tbl[i].e_err, tbl[i].e_fail, 1'b0));
      end

      // Auto-close: open for exactly OPN cycles
      reset_dut();
      enter(16'h2327);
      idle(1);
      chk("open_after_check", outs(), pk(1, 0, 0, 2'd0, 0));
      for (int k = 1; k < OPN; k++) begin
         idle(1);
         chk("open_hold", outs(), pk(1, 0, 0, 2'd0, 0));
      end
      idle(1);
      chk("auto_close", outs(), pk(0, 0, 0, 2'd0, 0));

      // Close coinciding with timer expiry
      reset_dut();
      enter(16'h2327);
      idle(OPN);
      step(0, 4'h0, 1, 0);
      chk("close_at_expiry", outs(), pk(0, 0, 0, 2'd0, 0));
      step(0, 4'h0, 1, 0);
      chk("closed_stays", outs(), pk(0, 0, 0, 2'd0, 0));
      enter(16'h2327);
      idle(1);
      chk("reopen_after_coinc", outs(), pk(1, 0, 0, 2'd0, 0));

      // Lockout after MF wrong entries
      reset_dut();
      for (int a = 0; a < MF; a++) begin
         enter(16'h1111);
         idle(1);
         chk($sformatf("wrong%0d", a), outs(), pk(0, a == MF - 1, 1, 2'(a + 1), 0));
      end
      for (int k = 1; k < LCK; k++) begin
         if (k <= 4) step(1, 4'(16'h2327 >> (4 * (4 - k))), 0, 0);
         else idle(1);
         chk("lock_hold", outs(), pk(0, 1, 0, 2'd3, 0));
      end
      idle(1);
      chk("lock_release", outs(), pk(0, 0, 0, 2'd0, 0));
      idle(2);
      chk("lock_ignored_digits", outs(), pk(0, 0, 0, 2'd0, 0));
      enter(16'h2327);
      idle(1);
      chk("open_after_lock", outs(), pk(1, 0, 0, 2'd0, 0));

      // Inter-digit timeout discards the partial entry without a failure
      reset_dut();
      enter(16'h1111);
      idle(1);
      chk("one_fail", outs(), pk(0, 0, 1, 2'd1, 0));
      step(1, 4'h2, 0, 0);
      step(1, 4'h3, 0, 0);
      idle(TMO);
      chk("tmo_no_fail", outs(), pk(0, 0, 0, 2'd1, 0));
      step(1, 4'h2, 0, 0);
      step(1, 4'h7, 0, 0);
      idle(2);
      chk("tmo_discarded", outs(), pk(0, 0, 0, 2'd1, 0));
      idle(TMO - 2);
      step(1, 4'h2, 0, 0);
      step(1, 4'h3, 0, 0);
      idle(TMO - 1);
      step(1, 4'h2, 0, 0);
      step(1, 4'h7, 0, 0);
      idle(1);
      chk("gap7_accepted", outs(), pk(1, 0, 0, 2'd0, 0));

      // Programming request in OPEN
      reset_dut();
      enter(16'h2327);
      idle(1);
      step(0, 4'h0, 0, 1);
      chk("prog_req_open", outs(), pk(1, 0, 0, 2'd0, 0));
      enter(16'h1111);
`ifdef CODE_PROG_EN
      chk("prog_done", outs(), pk(1, 0, 0, 2'd0, 1));
      idle(1);
      chk("prog_done_pulse", outs(), pk(1, 0, 0, 2'd0, 0));
      step(0, 4'h0, 1, 0);
      chk("prog_close", outs(), pk(0, 0, 0, 2'd0, 0));
      enter(16'h2327);
      idle(1);
      chk("old_code_rejected", outs(), pk(0, 0, 1, 2'd1, 0));
      enter(16'h1111);
      idle(1);
      chk("new_code_opens", outs(), pk(1, 0, 0, 2'd0, 0));
`else
      chk("prog_ignored", outs(), pk(1, 0, 0, 2'd0, 0));
      step(0, 4'h0, 1, 0);
      chk("prog_close", outs(), pk(0, 0, 0, 2'd0, 0));
      enter(16'h1111);
      idle(1);
      chk("code_unchanged", outs(), pk(0, 0, 1, 2'd1, 0));
      enter(16'h2327);
      idle(1);
      chk("default_opens", outs(), pk(1, 0, 0, 2'd0, 0));
`endif

      // Randomized run against the model
      reset_dut();
      pos = 0;
      pat = 16'h2327;
      for (int n = 0; n < 3000; n++) begin
         logic       vld, cls, prg;
         logic [3:0] cd;
         if (pos == 0) begin
            case ($urandom_range(0, 2))
               0:       pat = m_code;
               1:       pat = 16'($urandom);
               default: pat = m_code ^ 16'h0001;
            endcase
         end
         vld = ($urandom_range(0, 99) < 40);
         cd  = 4'($urandom);
         if (vld) begin
            cd  = 4'(pat >> (4 * (3 - pos)));
            pos = (pos + 1) % 4;
         end
         cls   = ($urandom_range(0, 29) == 0);
         prg   = ($urandom_range(0, 14) == 0);
         i_rst = ($urandom_range(0, 599) == 0);
         step(vld, cd, cls, prg);
         chk("rand", outs(), pk(m_open || m_prog, m_locked, m_err, 2'(m_fail), m_pdone));
      end
      i_rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
